yapp_input_arbiter: RTL
=======================

// Module: yapp_input_arbiter
// PURPOSE
//  Round-robin, packet-atomic arbiter sharing the single YAPP input port of yapp_router among NUM_SRC packet sources.
//  Sits between the sources and in_data/in_data_vld/in_suspend of the router, inside hw_top.
//  Parses each YAPP header to find the packet end, then forwards whole packets only.
//  Inserts the mandatory inter-packet gap and honours router back-pressure.
// PARAMETERS
//  NUM_SRC   4   number of requesting sources (2..8)
//  GAP_CYC   1   idle cycles with in_data_vld=0 between forwarded packets (>=1)
// PORTS
//  clock        in   1          single clock; all logic on posedge
//  reset        in   1          synchronous, active-high
//  src_data     in   NUM_SRC*8  byte from source i on [8*i+7:8*i]
//  src_vld      in   NUM_SRC    source i presents a valid byte
//  src_rdy      out  NUM_SRC    byte accepted when src_vld[i]&src_rdy[i]
//  in_data      out  8          YAPP byte to router
//  in_data_vld  out  1          YAPP valid to router
//  in_suspend   in   1          router back-pressure; byte consumed when in_data_vld & !in_suspend
//  grant        out  NUM_SRC    one-hot current packet owner; 0 when idle
//  busy         out  1          packet in flight (state != IDLE)
//  proto_err    out  1          sticky: owner dropped src_vld mid-packet; cleared only by reset
// BEHAVIOUR
//  Reset (sync, active-high):
//   - src_rdy, in_data, in_data_vld, grant, busy and proto_err all 0.
//   - RR pointer: source 0 highest priority. Any in-flight packet is abandoned; no partial bytes after reset.
//  Packet format: header {len[7:2], addr[1:0]}, then len payload bytes, then 1 parity byte (len+2 bytes total).
//  FSM IDLE -> XFER -> GAP -> IDLE:
//   - IDLE: if any src_vld, grant the first requester at or after the RR pointer (one-hot).
//     Next cycle: grant and busy high, enter XFER. Pointer = winner+1 mod NUM_SRC.
//   - XFER: src_rdy[g] = grant[g] & (!in_data_vld | !in_suspend); all other src_rdy = 0.
//     Accepted byte is registered into in_data with in_data_vld=1 the next cycle (1-cycle latency).
//     The output register holds in_data/in_data_vld unchanged while in_suspend=1.
//     Header acceptance loads remain = len+1 (6-bit len, 7-bit counter). Each later accepted byte decrements it.
//     The parity byte is the byte accepted with remain==1. After it, enter GAP.
//   - GAP: src_rdy=0.
//     When the last byte is consumed and no new byte is loaded, in_data_vld -> 0.
//     Stay until in_data_vld has been 0 for GAP_CYC cycles. Then grant=0, busy=0, IDLE.
//  Contiguity: once a header is accepted, the owner must keep src_vld high whenever src_rdy is high.
//   - If src_vld=0 while src_rdy=1 in XFER: set proto_err and drop in_data_vld for that cycle.
//   - Resume counting when the owner returns.
//  Boundaries:
//   - len=0: 2-byte packet (header, parity).
//   - len=63: 65 bytes; the counter never wraps.
//   - All sources requesting: strict rotation, packet-granular; no source waits more than NUM_SRC-1 packets.
//   - Single requester: re-granted after each GAP.
//   - in_suspend high at header time: header held on in_data, src_rdy=0 until released.
//   - in_suspend asserted in the same cycle as the last byte: byte held; GAP count starts after consumption.
//   - src_vld of non-owners is ignored during XFER/GAP.
// CONFIGURATION
//  YAPP_ARB_DROP_ADDR3_EN:
//   - Defined: header with addr==2'b11 marks the packet dropped. The whole packet (len+2 bytes) is drained
//     from the source with src_rdy=grant[g], ignoring in_suspend.
//     in_data_vld stays 0 for that packet; GAP is still applied; RR rotation unchanged.
//   - Undefined: addr==3 packets are forwarded unchanged; the router flags them.
// TESTING
//  1 Reset: assert reset 3 cycles with src_vld=4'hF -> all outputs 0. After release, grant=4'b0001 first.
//  2 Single packet: src0 sends hdr 8'h0D (len=3, addr=1), payload 11,22,33, parity.
//    -> in_data shows 5 bytes on 5 consecutive cycles, then in_data_vld=0 for 1 cycle, grant=0.
//  3 Round-robin: src0..src3 all request with 2-byte packets.
//    -> grant order 0001,0010,0100,1000,0001; each packet separated by GAP_CYC idle.
//  4 Suspend: in_suspend=1 for 4 cycles on payload byte 2.
//    -> in_data held at that byte, src_rdy[g]=0 for those cycles, no byte lost or duplicated.
//  5 Mid-packet bubble: owner drops src_vld for 1 cycle in payload.
//    -> proto_err=1 and stays 1; remaining bytes still counted correctly.
//  6 Drop feature (macro defined): src1 hdr 8'h0B (len=2, addr=3).
//    -> 4 bytes drained, in_data_vld stays 0, next grant goes to src2.

Source files
------------

// File: rtl/yapp_input_arbiter.sv
`timescale 1ns/1ps
// yapp_input_arbiter
// Round-robin, packet-atomic arbiter that shares the single YAPP input port of
// yapp_router among NUM_SRC packet sources. Each header is parsed to find the
// packet end, so only whole packets are forwarded, separated by GAP_CYC idle
// cycles, with router back-pressure (in_suspend) honoured throughout.
// Optional feature macro: YAPP_ARB_DROP_ADDR3_EN -- when defined, packets whose
// header carries addr==2'b11 are drained from the source and never forwarded.
module yapp_input_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int GAP_CYC = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_vld,
    output logic [NUM_SRC-1:0]   src_rdy,
    output logic [7:0]           in_data,
    output logic                 in_data_vld,
    input  logic                 in_suspend,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic                 proto_err
);

    localparam int PW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PW1 = PW + 1;
    localparam int GW  = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [7:0]           data_q, data_d;
    logic                 vld_q, vld_d;
    logic [6:0]           remain_q, remain_d;
    logic                 hdr_seen_q, hdr_seen_d;
    logic                 perr_q, perr_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 drop_q, drop_d;

    logic [7:0]           own_byte;
    logic                 own_vld;
    logic [PW-1:0]        win;
    logic [PW1-1:0]       sum;
    logic [PW-1:0]        cand;
    logic                 rdy_ok;
    logic                 accept;
    logic                 stall;
    logic                 hdr_drop;
    logic                 fwd;

    // Select the byte and valid of the current packet owner.
    always_comb begin
        own_byte = '0;
        own_vld  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner_q == PW'(i)) begin
                own_byte = src_data[8*i +: 8];
                own_vld  = src_vld[i];
            end
        end
    end

    // Find the first requester at or after the round-robin pointer; scanning
    // downwards lets the nearest candidate overwrite the farther ones.
    always_comb begin
        win  = ptr_q;
        sum  = '0;
        cand = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + PW1'(k);
            if (sum >= PW1'(NUM_SRC)) begin
                sum = sum - PW1'(NUM_SRC);
            end
            cand = sum[PW-1:0];
            if (src_vld[cand]) begin
                win = cand;
            end
        end
    end

    // A dropped packet is drained regardless of back-pressure because nothing
    // is being placed in the output register for it.
    assign rdy_ok  = drop_q | ~vld_q | ~in_suspend;
    assign src_rdy = (state_q == ST_XFER) ? (grant_q & {NUM_SRC{rdy_ok}}) : '0;
    assign accept  = (state_q == ST_XFER) & rdy_ok & own_vld;
    assign stall   = (state_q == ST_XFER) & hdr_seen_q & rdy_ok & ~own_vld;

`ifdef YAPP_ARB_DROP_ADDR3_EN
    assign hdr_drop = ~hdr_seen_q & (own_byte[1:0] == 2'b11);
`else
    assign hdr_drop = 1'b0;
`endif

    assign fwd = accept & ~(drop_q | hdr_drop);

    // Next-state logic: arbitration, packet length tracking, gap timing and
    // the one-deep output register towards the router.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        hdr_seen_d = hdr_seen_q;
        drop_d     = drop_q;
        gap_d      = gap_q;
        perr_d     = perr_q | stall;
        data_d     = data_q;
        vld_d      = vld_q;

        if (fwd) begin
            data_d = own_byte;
            vld_d  = 1'b1;
        end else if (!(vld_q && in_suspend)) begin
            vld_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|src_vld) begin
                    state_d    = ST_XFER;
                    grant_d    = NUM_SRC'(1) << win;
                    owner_d    = win;
                    ptr_d      = (win == PW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
                    hdr_seen_d = 1'b0;
                    drop_d     = 1'b0;
                    remain_d   = '0;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    if (!hdr_seen_q) begin
                        hdr_seen_d = 1'b1;
                        remain_d   = {1'b0, own_byte[7:2]} + 7'd1;
                        drop_d     = hdr_drop;
                    end else begin
                        remain_d = remain_q - 7'd1;
                        if (remain_q == 7'd1) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (!vld_q) begin
                    if (gap_q == GW'(GAP_CYC - 1)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            remain_q   <= '0;
            hdr_seen_q <= 1'b0;
            perr_q     <= 1'b0;
            gap_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            remain_q   <= remain_d;
            hdr_seen_q <= hdr_seen_d;
            perr_q     <= perr_d;
            gap_q      <= gap_d;
            drop_q     <= drop_d;
        end
    end

    assign in_data     = data_q;
    assign in_data_vld = vld_q;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign proto_err   = perr_q;

endmodule
